twiddle_seq_gen: RTL

//  Parametrised twiddle-factor generator for radix-2 DIT FFTs of N = 2**LOG2N points.

---
 rtl/twiddle_seq_gen_if.sv | 30 +++
 rtl/twiddle_seq_gen.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/twiddle_seq_gen_if.sv
// Request/response bundle for twiddle_seq_gen: stage-run and lookup requests in,
// twiddle beats out under valid/ready.
interface twiddle_seq_gen_if #(
  parameter int LOG2N = 6,
  parameter int W     = 16
);
  localparam int SW = $clog2(LOG2N);

  logic                 start;
  logic [SW-1:0]        stage;
  logic                 inverse;
  logic                 rd_valid;
  logic [LOG2N-2:0]     rd_k;
  logic                 busy;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [W-1:0]  out_real;
  logic signed [W-1:0]  out_imag;
  logic                 out_last;

  modport master (
    output start, stage, inverse, rd_valid, rd_k, out_ready,
    input  busy, out_valid, out_real, out_imag, out_last
  );

  modport slave (
    input  start, stage, inverse, rd_valid, rd_k, out_ready,
    output busy, out_valid, out_real, out_imag, out_last
  );
endinterface

// File: rtl/twiddle_seq_gen.sv
// Radix-2 DIT twiddle generator: quarter-wave cosine table folded to W_N^k, fed either by a
// per-stage butterfly-order sequencer or by single idle-time lookups. Two-stage pipeline.
module twiddle_seq_gen #(
  parameter int LOG2N = 6,
  parameter int W     = 16,
  parameter int FRAC  = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  twiddle_seq_gen_if.slave bus
);
  localparam int N  = 1 << LOG2N;
  localparam int Q  = N / 4;
  localparam int KW = LOG2N - 1;
  localparam int SW = $clog2(LOG2N);
  localparam logic [KW-1:0] QK     = KW'(Q);
  localparam logic [KW-1:0] B_LAST = KW'(N / 2 - 1);
  localparam real PI = 3.14159265358979323846;

  // Table is built at elaboration with round(cos(2*pi*i/N) * 2**FRAC), so no image file is needed.
  function automatic int cos_q(input int i);
    real x, term, sum, scale;
    x     = 2.0 * PI * real'(i) / real'(N);
    term  = 1.0;
    sum   = 1.0;
    for (int n = 1; n < 30; n++) begin
      term = -term * x * x / real'((2 * n - 1) * (2 * n));
      sum  = sum + term;
    end
    scale = 1.0;
    for (int f = 0; f < FRAC; f++) scale = scale * 2.0;
    return $rtoi(sum * scale + 0.5);
  endfunction

  logic signed [W-1:0] ctab [0:Q];
  for (genvar gi = 0; gi <= Q; gi++) begin : g_tab
    localparam int CV = cos_q(gi);
    assign ctab[gi] = W'(CV);
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
  state_e        state_q, state_d;
  logic [KW-1:0] b_q, b_d;
  logic [SW-1:0] stage_q, stage_d;
  logic          inv_q, inv_d;
  logic          en;
  logic [KW-1:0] j_mask, seq_k;
  logic          iss_vld, iss_inv, iss_last;
  logic [KW-1:0] iss_k;

  assign en = !bus.out_valid || bus.out_ready;

  always_comb begin
    j_mask = KW'((32'd1 << stage_q) - 32'd1);
    seq_k  = (b_q & j_mask) << (KW - 32'(stage_q));
  end

  // Requests only enter while the pipeline can advance; a stall freezes the sequencer too.
  always_comb begin
    state_d  = state_q;
    b_d      = b_q;
    stage_d  = stage_q;
    inv_d    = inv_q;
    iss_vld  = 1'b0;
    iss_k    = '0;
    iss_inv  = 1'b0;
    iss_last = 1'b0;
    unique case (state_q)
      IDLE: if (en) begin
        if (bus.start && (32'(bus.stage) < LOG2N)) begin
          state_d = RUN;
          b_d     = KW'(1);
          stage_d = bus.stage;
          inv_d   = bus.inverse;
          iss_vld = 1'b1;
          iss_inv = bus.inverse;
        end else if (bus.rd_valid && !bus.start) begin
          iss_vld = 1'b1;
          iss_k   = bus.rd_k;
          iss_inv = bus.inverse;
        end
      end
      RUN: if (en) begin
        iss_vld  = 1'b1;
        iss_k    = seq_k;
        iss_inv  = inv_q;
        iss_last = (b_q == B_LAST);
        b_d      = b_q + KW'(1);
        if (b_q == B_LAST) state_d = DRAIN;
      end
      DRAIN: if (bus.out_valid && bus.out_ready && bus.out_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      b_q     <= '0;
      stage_q <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      stage_q <= stage_d;
      inv_q   <= inv_d;
    end
  end

  // S1: fold k into table addresses and sign flags
  logic [KW-1:0] fold_re_idx, fold_im_idx;
  logic          fold_re_neg;

  always_comb begin
    if (iss_k <= QK) begin
      fold_re_idx = iss_k;
      fold_re_neg = 1'b0;
      fold_im_idx = QK - iss_k;
    end else begin
      fold_re_idx = QK - (iss_k - QK);
      fold_re_neg = 1'b1;
      fold_im_idx = iss_k - QK;
    end
  end

  logic          s1_vld_q, s1_last_q, s1_re_neg_q, s1_im_neg_q;
  logic [KW-1:0] s1_re_idx_q, s1_im_idx_q;

  always_ff @(posedge clk) begin
    if (en) begin
      s1_re_idx_q <= fold_re_idx;
      s1_im_idx_q <= fold_im_idx;
      s1_re_neg_q <= fold_re_neg;
      s1_im_neg_q <= !iss_inv;
      s1_last_q   <= iss_last;
    end
  end

  // S2: table read, sign apply, output register
  logic signed [W-1:0] re_mag, im_mag, re_d, im_d;
  logic signed [W-1:0] out_real_q, out_imag_q;
  logic                out_valid_q, out_last_q;

  always_comb begin
    re_mag = ctab[s1_re_idx_q];
    im_mag = ctab[s1_im_idx_q];
    re_d   = s1_re_neg_q ? -re_mag : re_mag;
    im_d   = s1_im_neg_q ? -im_mag : im_mag;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_real_q  <= '0;
      out_imag_q  <= '0;
    end else if (en) begin
      s1_vld_q    <= iss_vld;
      out_valid_q <= s1_vld_q;
      out_last_q  <= s1_vld_q && s1_last_q;
      if (s1_vld_q) begin
        out_real_q <= re_d;
        out_imag_q <= im_d;
      end
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_real  = out_real_q;
  assign bus.out_imag  = out_imag_q;
endmodule
